// File: rtl/lamp_ramp_driver.sv
// rtl/lamp_ramp_driver.sv - soft-ramping thermometer lamp driver
//
// Purpose:
//   Takes a requested number of lit lamps and walks a thermometer-coded
//   lamp enable bus toward it, one lamp every STEP_CYCLES clocks, so the
//   lamp bank never jumps. force_off drops every lamp on the next edge.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   target_valid  in   lamp-count request present
//   target        in   requested number of lit lamps (clamped to N_LAMPS)
//   target_ready  out  request accepted this cycle if target_valid is high
//   force_off     in   emergency all-off, overrides everything
//   lamp_en       out  bit i set iff i < lamp_count
//   lamp_count    out  lamps currently lit
//   busy          out  ramp in progress
//   settled       out  one-cycle pulse when a ramp reaches its target

module lamp_ramp_driver #(
   parameter int N_LAMPS     = 15,
   parameter int CNT_W       = 4,
   parameter int STEP_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               target_valid,
   input  logic [CNT_W-1:0]   target,
   output logic               target_ready,
   input  logic               force_off,
   output logic [N_LAMPS-1:0] lamp_en,
   output logic [CNT_W-1:0]   lamp_count,
   output logic               busy,
   output logic               settled
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int               TMR_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(N_LAMPS);

   state_t               state_q,   state_d;
   logic [CNT_W-1:0]     count_q,   count_d;
   logic [CNT_W-1:0]     tgt_q,     tgt_d;
   logic [TMR_W-1:0]     timer_q,   timer_d;
   logic [N_LAMPS-1:0]   lamp_en_q, lamp_en_d;
   logic                 busy_q,    busy_d;
   logic                 settled_q, settled_d;
   logic [CNT_W-1:0]     tgt_clamped;

   // Thermometer code: lamp i lit iff i < n.
   function automatic logic [N_LAMPS-1:0] therm(input logic [CNT_W-1:0] n);
      logic [N_LAMPS-1:0] t;
      for (int i = 0; i < N_LAMPS; i++) begin
         t[i] = (CNT_W'(i) < n);
      end
      return t;
   endfunction

   assign tgt_clamped  = (target > MAX_CNT) ? MAX_CNT : target;
   assign target_ready = (state_q == S_IDLE) && !force_off;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tgt_d   = tgt_q;
      timer_d = timer_q;

      case (state_q)
         S_IDLE: begin
            if (target_valid && target_ready) begin
               tgt_d   = tgt_clamped;
               timer_d = TMR_RELOAD;
               if (tgt_clamped > count_q) begin
                  state_d = S_UP;
               end else if (tgt_clamped < count_q) begin
                  state_d = S_DOWN;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_UP, S_DOWN: begin
            // Arrival check comes first, so DONE lands one edge after the
            // final toggle rather than on it.
            if (count_q == tgt_q) begin
               state_d = S_DONE;
            end else if (timer_q == '0) begin
               count_d = (state_q == S_UP) ? count_q + 1'b1 : count_q - 1'b1;
               timer_d = TMR_RELOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (force_off) begin
         state_d = S_IDLE;
         count_d = '0;
      end

      // Outputs are registered from next-state values so they move on the
      // same edge as the state and count.
      lamp_en_d = therm(count_d);
      busy_d    = (state_d == S_UP) || (state_d == S_DOWN);
      settled_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         tgt_q     <= '0;
         timer_q   <= '0;
         lamp_en_q <= '0;
         busy_q    <= 1'b0;
         settled_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         tgt_q     <= tgt_d;
         timer_q   <= timer_d;
         lamp_en_q <= lamp_en_d;
         busy_q    <= busy_d;
         settled_q <= settled_d;
      end
   end

   assign lamp_en    = lamp_en_q;
   assign lamp_count = count_q;
   assign busy       = busy_q;
   assign settled    = settled_q;

endmodule

// File: tb/tb_lamp_ramp_driver.sv
// tb/tb_lamp_ramp_driver.sv - scoreboard bench for lamp_ramp_driver

module tb_lamp_ramp_driver;

   localparam int NL = 12;
   localparam int CW = 4;
   localparam int ST = 4;

   logic          clk          = 1'b0;
   logic          rst_n        = 1'b0;
   logic          target_valid = 1'b0;
   logic [CW-1:0] target       = '0;
   logic          force_off    = 1'b0;
   logic          target_ready;
   logic [NL-1:0] lamp_en;
   logic [CW-1:0] lamp_count;
   logic          busy;
   logic          settled;

   lamp_ramp_driver #(.N_LAMPS(NL), .CNT_W(CW), .STEP_CYCLES(ST)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .target_valid (target_valid),
      .target       (target),
      .target_ready (target_ready),
      .force_off    (force_off),
      .lamp_en      (lamp_en),
      .lamp_count   (lamp_count),
      .busy         (busy),
      .settled      (settled)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit kind;   // 0: lamp_count change, 1: settled pulse
      int cyc;
      int cnt;
      int en;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   function automatic int therm(input int n);
      return (1 << n) - 1;
   endfunction

   // Monitor: every lamp_count change and every settled pulse is an event
   // that must match the head of the expectation queue.
   int prev_cnt = 0;

   task automatic ev(input bit k);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got kind %0d count %0d expected none at cyc %0d",
                  k, lamp_count, cyc);
      end else begin
         e = q.pop_front();
         chk("ev_kind", int'(k), int'(e.kind));
         chk("ev_cycle", cyc, e.cyc);
         chk("ev_count", int'(lamp_count), e.cnt);
         chk("ev_lamp_en", int'(lamp_en), e.en);
      end
   endtask

   always @(negedge clk) begin
      if (int'(lamp_count) != prev_cnt) begin
         ev(1'b0);
         prev_cnt = int'(lamp_count);
      end
      if (settled) ev(1'b1);
   end

   task automatic push(input bit k, input int c, input int n);
      exp_t e;
      e.kind = k;
      e.cyc  = c;
      e.cnt  = n;
      e.en   = therm(n);
      q.push_back(e);
   endtask

   // Steps from 'from' toward 'to' one per ST edges after accept edge e.
   task automatic expect_steps(input int e, input int from, input int to, input bit with_settle);
      int n;
      n = (to > from) ? to - from : from - to;
      for (int i = 1; i <= n; i++) begin
         push(1'b0, e + ST * i, (to > from) ? from + i : from - i);
      end
      if (with_settle) push(1'b1, (n == 0) ? e : e + ST * n + 1, to);
   endtask

   // Called at a negedge; the accept edge is the next posedge.
   task automatic go(input int t, input int from, input int to, input bit with_settle, output int e);
      e = cyc + 1;
      expect_steps(e, from, to, with_settle);
      target_valid = 1'b1;
      target       = CW'(t);
      @(negedge clk);
      target_valid = 1'b0;
   endtask

   task automatic wait_to(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected test end at cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      int e;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_count", int'(lamp_count), 0);
      chk("rst_lamp_en", int'(lamp_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_settled", int'(settled), 0);
      chk("rst_ready", int'(target_ready), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Up ramp 0 -> 3
      go(3, 0, 3, 1'b1, e);
      chk("up_busy", int'(busy), 1);
      chk("up_ready", int'(target_ready), 0);
      wait_to(e + 13);
      chk("up_settled", int'(settled), 1);
      wait_to(e + 14);
      chk("up_ready_back", int'(target_ready), 1);
      chk("up_busy_off", int'(busy), 0);

      // Setup 3 -> 5, then down ramp 5 -> 2
      go(5, 3, 5, 1'b1, e);
      wait_to(e + 10);
      go(2, 5, 2, 1'b1, e);
      wait_to(e + 14);
      chk("down_lamp_en", int'(lamp_en), 'h003);

      // No-op at 2
      go(2, 2, 2, 1'b1, e);
      chk("noop_settled", int'(settled), 1);
      chk("noop_lamp_en", int'(lamp_en), 'h003);
      wait_to(e + 1);
      chk("noop_ready", int'(target_ready), 1);
      chk("noop_lamp_en2", int'(lamp_en), 'h003);

      // Ignored request during up ramp 2 -> 6
      go(6, 2, 6, 1'b1, e);
      wait_to(e + 5);
      target_valid = 1'b1;
      target       = 4'd0;
      @(negedge clk);
      chk("ign_ready", int'(target_ready), 0);
      repeat (3) @(negedge clk);
      target_valid = 1'b0;
      wait_to(e + 18);
      chk("ign_count", int'(lamp_count), 6);

      // Clamp: 15 requested, N_LAMPS = 12
      go(15, 6, 12, 1'b1, e);
      wait_to(e + 26);
      chk("clamp_lamp_en", int'(lamp_en), 'hFFF);
      repeat (8) @(negedge clk);
      chk("clamp_count", int'(lamp_count), 12);
      chk("clamp_busy", int'(busy), 0);

      // Async reset mid down ramp 12 -> 0
      go(0, 12, 10, 1'b0, e);
      wait_to(e + 9);
      #2;
      rst_n = 1'b0;
      push(1'b0, e + 10, 0);
      #1;
      chk("arst_count", int'(lamp_count), 0);
      chk("arst_lamp_en", int'(lamp_en), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_settled", int'(settled), 0);
      chk("arst_ready", int'(target_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // force_off during up ramp 0 -> 5 at count 2
      go(5, 0, 2, 1'b0, e);
      wait_to(e + 9);
      chk("fo_pre_count", int'(lamp_count), 2);
      force_off    = 1'b1;
      target_valid = 1'b1;
      target       = 4'd5;
      push(1'b0, e + 10, 0);
      @(negedge clk);
      chk("fo_count", int'(lamp_count), 0);
      chk("fo_lamp_en", int'(lamp_en), 0);
      chk("fo_busy", int'(busy), 0);
      chk("fo_ready", int'(target_ready), 0);
      repeat (4) @(negedge clk);
      chk("fo_hold_count", int'(lamp_count), 0);
      chk("fo_hold_busy", int'(busy), 0);
      chk("fo_hold_ready", int'(target_ready), 0);
      target_valid = 1'b0;
      @(negedge clk);
      force_off = 1'b0;
      @(negedge clk);
      chk("fo_release_ready", int'(target_ready), 1);

      // Accept works again after reset and force_off
      go(1, 0, 1, 1'b1, e);
      wait_to(e + 8);
      chk("final_count", int'(lamp_count), 1);

      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
